// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data RAM responder.
package data_ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int          DEFAULT_ADDR_WIDTH = 12;
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0000;
    localparam int          ERR_CNT_W          = 8;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// Single-port word array with byte-lane write enables and a registered,
// write-first read port that can be forced to return zero.
module data_ram_bank
    import data_ram_pkg::*;
#(
    parameter int WORD_AW = 10
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [3:0]         we_i,
    input  logic [WORD_AW-1:0] idx_i,
    input  logic [31:0]        wdata_i,
    input  logic               zero_i,
    output logic [31:0]        rdata_o
);

    localparam int DEPTH = 1 << WORD_AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage is never reset; the responder sweeps it to zero instead.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (en_i && we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register: merged word on writes, held when idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 32'h0000_0000;
        end else if (en_i) begin
            if (zero_i) begin
                rdata_q <= 32'h0000_0000;
            end else begin
                rdata_q <= lane_merge(mem_q[idx_i], wdata_i, we_i);
            end
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// CPU data-port RAM responder: post-reset clear sweep, address decode and
// optional out-of-range error logging (enabled by DATA_RAM_ERR_LOG_EN).
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  write_sel,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy
`ifdef DATA_RAM_ERR_LOG_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_addr
`endif
);

    localparam int                 WORD_AW  = ADDR_WIDTH - 2;
    localparam logic [WORD_AW-1:0] LAST_IDX = {WORD_AW{1'b1}};
    localparam logic [WORD_AW-1:0] IDX_ONE  = {{(WORD_AW-1){1'b0}}, 1'b1};

    state_e             state_q;
    logic [WORD_AW-1:0] clr_idx_q;
    logic               busy_q;

    logic               in_range_s;
    logic [WORD_AW-1:0] word_idx_s;
    logic               bank_en_s;
    logic [3:0]         bank_we_s;
    logic [WORD_AW-1:0] bank_idx_s;
    logic [31:0]        bank_wdata_s;
    logic               bank_zero_s;
    logic               unused_addr_s;

    assign in_range_s    = (addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign word_idx_s    = addr[ADDR_WIDTH-1:2];
    assign unused_addr_s = ^addr[1:0];

    // Clear sweep and ready-state sequencing; busy is a state-aligned register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= {WORD_AW{1'b0}};
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q   <= READY;
                        clr_idx_q <= {WORD_AW{1'b0}};
                        busy_q    <= 1'b0;
                    end else begin
                        state_q   <= CLEAR;
                        clr_idx_q <= clr_idx_q + IDX_ONE;
                        busy_q    <= 1'b1;
                    end
                end
                READY: begin
                    state_q   <= READY;
                    clr_idx_q <= {WORD_AW{1'b0}};
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_idx_q <= {WORD_AW{1'b0}};
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Bank steering: sweep owns the array in CLEAR, CPU port owns it in READY.
    always_comb begin
        bank_en_s    = 1'b0;
        bank_we_s    = 4'h0;
        bank_idx_s   = word_idx_s;
        bank_wdata_s = data_in;
        bank_zero_s  = 1'b1;
        case (state_q)
            CLEAR: begin
                bank_en_s    = 1'b1;
                bank_we_s    = 4'hF;
                bank_idx_s   = clr_idx_q;
                bank_wdata_s = 32'h0000_0000;
                bank_zero_s  = 1'b1;
            end
            READY: begin
                bank_en_s    = en;
                bank_we_s    = in_range_s ? write_sel : 4'h0;
                bank_idx_s   = word_idx_s;
                bank_wdata_s = data_in;
                bank_zero_s  = ~in_range_s;
            end
            default: begin
                bank_en_s = 1'b0;
            end
        endcase
    end

    data_ram_bank #(
        .WORD_AW (WORD_AW)
    ) u_bank (
        .clk_i   (clk),
        .rst_n_i (rst),
        .en_i    (bank_en_s),
        .we_i    (bank_we_s),
        .idx_i   (bank_idx_s),
        .wdata_i (bank_wdata_s),
        .zero_i  (bank_zero_s),
        .rdata_o (data_out)
    );

    assign busy = busy_q;

`ifdef DATA_RAM_ERR_LOG_EN
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [31:0]          err_addr_q;

    // Saturating count and last-address capture of out-of-range accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q  <= {ERR_CNT_W{1'b0}};
            err_addr_q <= 32'h0000_0000;
        end else if ((state_q == READY) && en && !in_range_s) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_q <= err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
            err_addr_q <= addr;
        end else begin
            err_cnt_q  <= err_cnt_q;
            err_addr_q <= err_addr_q;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed scoreboard bench for data_ram_responder (default 4 KiB region at 0).
module tb_data_ram_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  write_sel;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
`ifdef DATA_RAM_ERR_LOG_EN
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;
    logic [7:0]  exp_err_cnt;
    logic [31:0] exp_err_addr;
`endif

    int n_cmp;
    int n_fail;

    logic [31:0] model [1024];
    logic [31:0] last_exp;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    data_ram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .write_sel (write_sel),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy)
`ifdef DATA_RAM_ERR_LOG_EN
        ,
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model[i] = 32'h0000_0000;
        last_exp = 32'h0000_0000;
`ifdef DATA_RAM_ERR_LOG_EN
        exp_err_cnt  = 8'h00;
        exp_err_addr = 32'h0000_0000;
`endif
    endtask

    // One READY-state access: model predicts, DUT is sampled 1 ns after the edge.
    task automatic access(input logic e, input logic [3:0] ws, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        logic [31:0] exp;
        logic        inr;
        int          idx;
        inr = (a[31:12] == 20'h00000);
        idx = int'(a[11:2]);
        exp = last_exp;
        if (e) begin
            if (!inr) begin
                exp = 32'h0000_0000;
`ifdef DATA_RAM_ERR_LOG_EN
                if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'h01;
                exp_err_addr = a;
`endif
            end else begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) model[idx][8*i +: 8] = d[8*i +: 8];
                exp = model[idx];
            end
        end
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        en = e; write_sel = ws; addr = a; data_in = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        check(tag_q.pop_front(), data_out, exp_q.pop_front());
        last_exp = exp;
    endtask

    // Releases reset and runs the sweep, optionally poking writes at 0x0.
    task automatic sweep(input string tag, input bit poke);
        int cycles;
        rst = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 1100) begin
            if (poke && cycles < 10) begin
                en = 1'b1; write_sel = 4'hF; addr = 32'h0; data_in = 32'hFFFF_FFFF;
            end else begin
                en = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 10) check({tag, "_dout_in_clear"}, data_out, 32'h0000_0000);
        end
        en = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cycles), 32'd1024);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rws;
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; en = 1'b0; write_sel = 4'h0; addr = 32'h0; data_in = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h1);
        check("reset_dout", data_out, 32'h0);

        sweep("first", 1'b1);
        access(1'b1, 4'h0, 32'h0000_0000, 32'h0, "clear_write_ignored");
        access(1'b1, 4'h0, 32'h0000_0FFC, 32'h0, "read_top_word");

        access(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, "wr_full");
        access(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500, "wr_lane1");
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "rd_merged");
        check("rd_merged_const", last_exp, 32'hDEAD_55EF);

        access(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, "b2b_wr");
        access(1'b1, 4'h0, 32'h0000_0023, 32'h0, "b2b_rd");
        access(1'b0, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, "idle_hold");
        access(1'b1, 4'b1001, 32'h0000_0020, 32'hAABB_CCDD, "wr_lanes30");
        access(1'b1, 4'h0, 32'h0000_0020, 32'h0, "rd_lanes30");
        check("rd_lanes30_const", last_exp, 32'hAA34_56DD);

        access(1'b1, 4'h0, 32'h0000_1000, 32'h0, "oor_read");
        access(1'b1, 4'hF, 32'h0000_2010, 32'hFFFF_FFFF, "oor_write");
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "oor_no_alias");
        access(1'b1, 4'h0, 32'h8000_0020, 32'h0, "oor_high");

        for (int i = 0; i < 40; i++) begin
            ra  = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) ra[12 + $urandom_range(0, 19)] = 1'b1;
            rws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            access(($urandom_range(0, 5) != 0), rws, ra, $urandom, $sformatf("rand%0d", i));
        end

        access(1'b1, 4'h0, 32'h0000_1000, 32'h0, "oor_rd_1000");
        for (int i = 0; i < 256; i++)
            access(1'b1, 4'hF, 32'h0001_0000 + 32'(i * 4), 32'hA5A5_A5A5, "oor_burst");
`ifdef DATA_RAM_ERR_LOG_EN
        check("err_cnt_sat", {24'h0, err_cnt}, {24'h0, exp_err_cnt});
        check("err_cnt_ff", {24'h0, err_cnt}, 32'h0000_00FF);
        check("err_addr_last", err_addr, exp_err_addr);
`endif
        access(1'b1, 4'h0, 32'h0000_0020, 32'h0, "after_burst_rd");

        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_clear();
        repeat (500) @(posedge clk);
        #1;
        check("mid_sweep_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_reset_busy", {31'h0, busy}, 32'h1);
        check("mid_reset_dout", data_out, 32'h0);
`ifdef DATA_RAM_ERR_LOG_EN
        check("mid_reset_errcnt", {24'h0, err_cnt}, 32'h0);
        check("mid_reset_erraddr", err_addr, 32'h0);
`endif
        @(posedge clk);
        #1;
        sweep("restart", 1'b0);
        access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "restart_rd10");
        access(1'b1, 4'h0, 32'h0000_0020, 32'h0, "restart_rd20");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
